// File: rtl/de_pipe_regs.sv
// -----------------------------------------------------------------------------
// de_pipe_regs
//
// Consumer side of the pipeline hazard interface for the 5-stage MIPS core.
// Applies the hazard unit's stall request and D-stage forward selects to the
// IF/ID and ID/EX pipeline registers:
//   - PC hold enable (pc_en = ~delay)
//   - D-stage rs/rt operand forwarding mux
//   - IF/ID hold and bubble injection into ID/EX while stalled
//   - two-state stall tracker driving the registered 'stalled' flag
//
// Optional build macro: DE_STALL_STAT_EN
//   When defined, adds stall statistics outputs stall_cnt, max_run, watchdog.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   delay       in   stall request from hazard unit
//   ir_f, pc_f  in   fetched instruction and its PC
//   rf_rs/rf_rt in   register-file reads for ir_d
//   ForwardRSD  in   rs select: 0 rf, 1 wd_w, 2 pc_m+8, 3 alu_m, 4 pc_e_fwd+8
//   ForwardRTD  in   rt select, same encoding (5-7 fall back to rf)
//   wd_w        in   W-stage writeback data
//   alu_m       in   M-stage ALU result
//   pc_m        in   M-stage PC
//   pc_e_fwd    in   E-stage PC
//   pc_en       out  PC register write enable
//   ir_d, pc_d  out  IF/ID instruction and PC
//   rs_d_val    out  forwarded rs operand (D stage, combinational)
//   rt_d_val    out  forwarded rt operand (D stage, combinational)
//   ir_e, pc_e  out  ID/EX instruction and PC
//   rs_e_val    out  ID/EX registered rs operand
//   rt_e_val    out  ID/EX registered rt operand
//   stalled     out  ID/EX currently holds an injected bubble
//   stall_cnt   out  (DE_STALL_STAT_EN) total stalled edges, wrapping
//   max_run     out  (DE_STALL_STAT_EN) longest stall run, saturating
//   watchdog    out  (DE_STALL_STAT_EN) sticky: a run reached 16 cycles
// -----------------------------------------------------------------------------
module de_pipe_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        delay,
   input  logic [31:0] ir_f,
   input  logic [31:0] pc_f,
   input  logic [31:0] rf_rs,
   input  logic [31:0] rf_rt,
   input  logic [2:0]  ForwardRSD,
   input  logic [2:0]  ForwardRTD,
   input  logic [31:0] wd_w,
   input  logic [31:0] alu_m,
   input  logic [31:0] pc_m,
   input  logic [31:0] pc_e_fwd,
   output logic        pc_en,
   output logic [31:0] ir_d,
   output logic [31:0] pc_d,
   output logic [31:0] rs_d_val,
   output logic [31:0] rt_d_val,
   output logic [31:0] ir_e,
   output logic [31:0] pc_e,
   output logic [31:0] rs_e_val,
   output logic [31:0] rt_e_val,
   output logic        stalled
`ifdef DE_STALL_STAT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [15:0] max_run,
   output logic        watchdog
`endif
);

   typedef enum logic {
      RUN    = 1'b0,
      BUBBLE = 1'b1
   } state_t;

   state_t state;

   // Link-address sources (jal/jalr results still in flight) are PC + 8.
   logic [31:0] pc_m_link;
   logic [31:0] pc_e_link;

   assign pc_m_link = pc_m + 32'd8;
   assign pc_e_link = pc_e_fwd + 32'd8;

   assign pc_en = ~delay;

   // D-stage forwarding mux; unused codes fall back to the register file.
   always_comb begin
      rs_d_val = rf_rs;
      case (ForwardRSD)
         3'd1:    rs_d_val = wd_w;
         3'd2:    rs_d_val = pc_m_link;
         3'd3:    rs_d_val = alu_m;
         3'd4:    rs_d_val = pc_e_link;
         default: rs_d_val = rf_rs;
      endcase
   end

   always_comb begin
      rt_d_val = rf_rt;
      case (ForwardRTD)
         3'd1:    rt_d_val = wd_w;
         3'd2:    rt_d_val = pc_m_link;
         3'd3:    rt_d_val = alu_m;
         3'd4:    rt_d_val = pc_e_link;
         default: rt_d_val = rf_rt;
      endcase
   end

   // IF/ID register: holds while a stall is requested.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_d <= NOP_IR;
         pc_d <= RESET_PC;
      end else if (!delay) begin
         ir_d <= ir_f;
         pc_d <= pc_f;
      end
   end

   // ID/EX register: a stall injects a bubble but keeps the held
   // instruction's PC so the bubble is traceable to it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_e     <= NOP_IR;
         pc_e     <= RESET_PC;
         rs_e_val <= '0;
         rt_e_val <= '0;
      end else begin
         pc_e <= pc_d;
         if (delay) begin
            ir_e     <= NOP_IR;
            rs_e_val <= '0;
            rt_e_val <= '0;
         end else begin
            ir_e     <= ir_d;
            rs_e_val <= rs_d_val;
            rt_e_val <= rt_d_val;
         end
      end
   end

   // Stall tracker: stalled mirrors the next state so it is aligned with
   // the bubble entering ID/EX on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RUN;
         stalled <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (delay) begin
                  state   <= BUBBLE;
                  stalled <= 1'b1;
               end else begin
                  state   <= RUN;
                  stalled <= 1'b0;
               end
            end
            BUBBLE: begin
               if (delay) begin
                  state   <= BUBBLE;
                  stalled <= 1'b1;
               end else begin
                  state   <= RUN;
                  stalled <= 1'b0;
               end
            end
            default: begin
               state   <= RUN;
               stalled <= 1'b0;
            end
         endcase
      end
   end

`ifdef DE_STALL_STAT_EN
   logic [15:0] cur_run;
   logic [15:0] run_nxt;

   // Run length including the current edge, saturating at all-ones.
   assign run_nxt = (cur_run == '1) ? cur_run : cur_run + 16'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         cur_run   <= '0;
         max_run   <= '0;
         watchdog  <= 1'b0;
      end else if (delay) begin
         stall_cnt <= stall_cnt + 32'd1;
         cur_run   <= run_nxt;
         if (run_nxt > max_run)
            max_run <= run_nxt;
         if (run_nxt >= 16'd16)
            watchdog <= 1'b1;
      end else begin
         cur_run <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_de_pipe_regs.sv
// -----------------------------------------------------------------------------
// tb_de_pipe_regs
//
// Self-checking bench for de_pipe_regs: a combinational forwarding table,
// a sequential table covering streaming, single and multi-cycle stalls, and
// hand-written sequences for reset mid-stall and (DE_STALL_STAT_EN) the
// stall statistics / watchdog.
// -----------------------------------------------------------------------------
module tb_de_pipe_regs;

   logic        clk;
   logic        reset;
   logic        delay;
   logic [31:0] ir_f;
   logic [31:0] pc_f;
   logic [31:0] rf_rs;
   logic [31:0] rf_rt;
   logic [2:0]  ForwardRSD;
   logic [2:0]  ForwardRTD;
   logic [31:0] wd_w;
   logic [31:0] alu_m;
   logic [31:0] pc_m;
   logic [31:0] pc_e_fwd;
   logic        pc_en;
   logic [31:0] ir_d;
   logic [31:0] pc_d;
   logic [31:0] rs_d_val;
   logic [31:0] rt_d_val;
   logic [31:0] ir_e;
   logic [31:0] pc_e;
   logic [31:0] rs_e_val;
   logic [31:0] rt_e_val;
   logic        stalled;
`ifdef DE_STALL_STAT_EN
   logic [31:0] stall_cnt;
   logic [15:0] max_run;
   logic        watchdog;
`endif

   int checks = 0;
   int errors = 0;

   de_pipe_regs #(
      .RESET_PC (32'h0000_3000),
      .NOP_IR   (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .delay      (delay),
      .ir_f       (ir_f),
      .pc_f       (pc_f),
      .rf_rs      (rf_rs),
      .rf_rt      (rf_rt),
      .ForwardRSD (ForwardRSD),
      .ForwardRTD (ForwardRTD),
      .wd_w       (wd_w),
      .alu_m      (alu_m),
      .pc_m       (pc_m),
      .pc_e_fwd   (pc_e_fwd),
      .pc_en      (pc_en),
      .ir_d       (ir_d),
      .pc_d       (pc_d),
      .rs_d_val   (rs_d_val),
      .rt_d_val   (rt_d_val),
      .ir_e       (ir_e),
      .pc_e       (pc_e),
      .rs_e_val   (rs_e_val),
      .rt_e_val   (rt_e_val),
      .stalled    (stalled)
`ifdef DE_STALL_STAT_EN
      ,
      .stall_cnt  (stall_cnt),
      .max_run    (max_run),
      .watchdog   (watchdog)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  frs;
      logic [2:0]  frt;
      logic [31:0] pcm;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
   } fwd_vec_t;

   typedef struct {
      logic        dly;
      logic [31:0] irf;
      logic [31:0] pcf;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [2:0]  frs;
      logic [2:0]  frt;
      logic        e_pc_en;
      logic [31:0] e_rs_d;
      logic [31:0] e_rt_d;
      logic [31:0] e_ir_d;
      logic [31:0] e_pc_d;
      logic [31:0] e_ir_e;
      logic [31:0] e_pc_e;
      logic [31:0] e_rs_e;
      logic [31:0] e_rt_e;
      logic        e_st;
   } seq_vec_t;

   localparam int NFWD = 7;
   localparam int NSEQ = 10;

   fwd_vec_t fv [NFWD];
   seq_vec_t sv [NSEQ];

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic step();
      if ($isunknown(delay)) begin
         errors++;
         $display("FAIL delay_x: got %b expected 0 or 1", delay);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input int idx);
      chk("rst_ir_d", idx, ir_d, 32'h0000_0000);
      chk("rst_pc_d", idx, pc_d, 32'h0000_3000);
      chk("rst_ir_e", idx, ir_e, 32'h0000_0000);
      chk("rst_pc_e", idx, pc_e, 32'h0000_3000);
      chk("rst_rs_e", idx, rs_e_val, 32'h0000_0000);
      chk("rst_rt_e", idx, rt_e_val, 32'h0000_0000);
      chk("rst_stalled", idx, 32'(stalled), 32'd0);
   endtask

   initial begin
      // Forwarding table: rf_rs=0x11, rf_rt=0x55, wd_w=0x22, alu_m=0x44,
      // pc_e_fwd=0x3020; pc_m per row.
      fv[0] = '{3'd0, 3'd4, 32'h0000_3010, 32'h0000_0011, 32'h0000_3028};
      fv[1] = '{3'd1, 3'd3, 32'h0000_3010, 32'h0000_0022, 32'h0000_0044};
      fv[2] = '{3'd2, 3'd2, 32'h0000_3010, 32'h0000_3018, 32'h0000_3018};
      fv[3] = '{3'd3, 3'd1, 32'h0000_3010, 32'h0000_0044, 32'h0000_0022};
      fv[4] = '{3'd4, 3'd0, 32'h0000_3010, 32'h0000_3028, 32'h0000_0055};
      fv[5] = '{3'd6, 3'd5, 32'h0000_3010, 32'h0000_0011, 32'h0000_0055};
      fv[6] = '{3'd2, 3'd7, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0055};

      // Sequential table, starting from reset state; wd_w=0x22, alu_m=0x44,
      // pc_m=0x3010, pc_e_fwd=0x3020 throughout.
      //        dly   ir_f          pc_f          rf_rs         rf_rt         frs   frt   pc_en rs_d          rt_d          ir_d          pc_d          ir_e          pc_e          rs_e          rt_e          st
      sv[0] = '{1'b0, 32'h2408_0001, 32'h0000_3000, 32'h0000_00A0, 32'h0000_00B0, 3'd0, 3'd0, 1'b1, 32'h0000_00A0, 32'h0000_00B0, 32'h2408_0001, 32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 32'h0000_00A0, 32'h0000_00B0, 1'b0};
      sv[1] = '{1'b0, 32'h2409_0002, 32'h0000_3004, 32'h0000_00A1, 32'h0000_00B1, 3'd0, 3'd0, 1'b1, 32'h0000_00A1, 32'h0000_00B1, 32'h2409_0002, 32'h0000_3004, 32'h2408_0001, 32'h0000_3000, 32'h0000_00A1, 32'h0000_00B1, 1'b0};
      sv[2] = '{1'b0, 32'h8D09_0000, 32'h0000_3008, 32'h0000_00A2, 32'h0000_00B2, 3'd1, 3'd3, 1'b1, 32'h0000_0022, 32'h0000_0044, 32'h8D09_0000, 32'h0000_3008, 32'h2409_0002, 32'h0000_3004, 32'h0000_0022, 32'h0000_0044, 1'b0};
      sv[3] = '{1'b1, 32'h0109_5020, 32'h0000_300C, 32'h0000_00A3, 32'h0000_00B3, 3'd0, 3'd0, 1'b0, 32'h0000_00A3, 32'h0000_00B3, 32'h8D09_0000, 32'h0000_3008, 32'h0000_0000, 32'h0000_3008, 32'h0000_0000, 32'h0000_0000, 1'b1};
      sv[4] = '{1'b0, 32'h0109_5020, 32'h0000_300C, 32'h0000_00A4, 32'h0000_00B4, 3'd2, 3'd4, 1'b1, 32'h0000_3018, 32'h0000_3028, 32'h0109_5020, 32'h0000_300C, 32'h8D09_0000, 32'h0000_3008, 32'h0000_3018, 32'h0000_3028, 1'b0};
      sv[5] = '{1'b1, 32'hAC0A_0004, 32'h0000_3010, 32'h0000_00A5, 32'h0000_00B5, 3'd0, 3'd0, 1'b0, 32'h0000_00A5, 32'h0000_00B5, 32'h0109_5020, 32'h0000_300C, 32'h0000_0000, 32'h0000_300C, 32'h0000_0000, 32'h0000_0000, 1'b1};
      sv[6] = '{1'b1, 32'hAC0A_0004, 32'h0000_3010, 32'h0000_00A6, 32'h0000_00B6, 3'd0, 3'd0, 1'b0, 32'h0000_00A6, 32'h0000_00B6, 32'h0109_5020, 32'h0000_300C, 32'h0000_0000, 32'h0000_300C, 32'h0000_0000, 32'h0000_0000, 1'b1};
      sv[7] = '{1'b1, 32'hAC0A_0004, 32'h0000_3010, 32'h0000_00A7, 32'h0000_00B7, 3'd0, 3'd0, 1'b0, 32'h0000_00A7, 32'h0000_00B7, 32'h0109_5020, 32'h0000_300C, 32'h0000_0000, 32'h0000_300C, 32'h0000_0000, 32'h0000_0000, 1'b1};
      sv[8] = '{1'b0, 32'hAC0A_0004, 32'h0000_3010, 32'h0000_00A8, 32'h0000_00B8, 3'd0, 3'd1, 1'b1, 32'h0000_00A8, 32'h0000_0022, 32'hAC0A_0004, 32'h0000_3010, 32'h0109_5020, 32'h0000_300C, 32'h0000_00A8, 32'h0000_0022, 1'b0};
      sv[9] = '{1'b0, 32'h1000_0003, 32'h0000_3014, 32'h0000_00A9, 32'h0000_00B9, 3'd6, 3'd7, 1'b1, 32'h0000_00A9, 32'h0000_00B9, 32'h1000_0003, 32'h0000_3014, 32'hAC0A_0004, 32'h0000_3010, 32'h0000_00A9, 32'h0000_00B9, 1'b0};

      reset      = 1'b0;
      delay      = 1'b0;
      ir_f       = 32'h0;
      pc_f       = 32'h0;
      rf_rs      = 32'h0;
      rf_rt      = 32'h0;
      ForwardRSD = 3'd0;
      ForwardRTD = 3'd0;
      wd_w       = 32'h0;
      alu_m      = 32'h0;
      pc_m       = 32'h0;
      pc_e_fwd   = 32'h0;

      #1 reset = 1'b1;
      #1;
      chk_reset_state(0);

      // Combinational forwarding table.
      rf_rs    = 32'h0000_0011;
      rf_rt    = 32'h0000_0055;
      wd_w     = 32'h0000_0022;
      alu_m    = 32'h0000_0044;
      pc_e_fwd = 32'h0000_3020;
      for (int i = 0; i < NFWD; i++) begin
         ForwardRSD = fv[i].frs;
         ForwardRTD = fv[i].frt;
         pc_m       = fv[i].pcm;
         #1;
         chk("fwd_rs", i, rs_d_val, fv[i].e_rs);
         chk("fwd_rt", i, rt_d_val, fv[i].e_rt);
      end

      step();
      step();
      pc_m     = 32'h0000_3010;
      reset    = 1'b0;

      // Sequential table.
      for (int i = 0; i < NSEQ; i++) begin
         delay      = sv[i].dly;
         ir_f       = sv[i].irf;
         pc_f       = sv[i].pcf;
         rf_rs      = sv[i].rs;
         rf_rt      = sv[i].rt;
         ForwardRSD = sv[i].frs;
         ForwardRTD = sv[i].frt;
         #1;
         chk("pc_en", i, 32'(pc_en), 32'(sv[i].e_pc_en));
         chk("rs_d_val", i, rs_d_val, sv[i].e_rs_d);
         chk("rt_d_val", i, rt_d_val, sv[i].e_rt_d);
         step();
         chk("ir_d", i, ir_d, sv[i].e_ir_d);
         chk("pc_d", i, pc_d, sv[i].e_pc_d);
         chk("ir_e", i, ir_e, sv[i].e_ir_e);
         chk("pc_e", i, pc_e, sv[i].e_pc_e);
         chk("rs_e_val", i, rs_e_val, sv[i].e_rs_e);
         chk("rt_e_val", i, rt_e_val, sv[i].e_rt_e);
         chk("stalled", i, 32'(stalled), 32'(sv[i].e_st));
`ifdef DE_STALL_STAT_EN
         if (i == 8) begin
            chk("stall_cnt", i, stall_cnt, 32'd4);
            chk("max_run", i, 32'(max_run), 32'd3);
            chk("watchdog", i, 32'(watchdog), 32'd0);
         end
`endif
      end

      // Reset asserted mid-stall, then delay held through reset release.
      delay = 1'b1;
      ir_f  = 32'h2410_0007;
      pc_f  = 32'h0000_3000;
      step();
      step();
      chk("stall_ir_d", 0, ir_d, 32'h1000_0003);
      chk("stall_ir_e", 0, ir_e, 32'h0000_0000);
      chk("stall_st", 0, 32'(stalled), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk_reset_state(1);
      chk("rst_pc_en", 1, 32'(pc_en), 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_ir_d", 0, ir_d, 32'h0000_0000);
      chk("post_rst_ir_e", 0, ir_e, 32'h0000_0000);
      chk("post_rst_pc_e", 0, pc_e, 32'h0000_3000);
      chk("post_rst_st", 0, 32'(stalled), 32'd1);
      delay = 1'b0;
      step();
      chk("resume_ir_d", 0, ir_d, 32'h2410_0007);
      chk("resume_pc_d", 0, pc_d, 32'h0000_3000);
      chk("resume_st", 0, 32'(stalled), 32'd0);
      ir_f = 32'h2411_0008;
      pc_f = 32'h0000_3004;
      step();
      chk("resume_ir_e", 0, ir_e, 32'h2410_0007);
      chk("resume_pc_e", 0, pc_e, 32'h0000_3000);
      chk("resume_ir_d", 1, ir_d, 32'h2411_0008);

`ifdef DE_STALL_STAT_EN
      // 16-cycle stall run trips the sticky watchdog.
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      chk("stat_rst_cnt", 0, stall_cnt, 32'd0);
      delay = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         if (i == 14)
            chk("wd_early", i, 32'(watchdog), 32'd0);
      end
      chk("wd_set", 0, 32'(watchdog), 32'd1);
      chk("wd_cnt", 0, stall_cnt, 32'd16);
      chk("wd_max", 0, 32'(max_run), 32'd16);
      delay = 1'b0;
      step();
      step();
      chk("wd_sticky", 0, 32'(watchdog), 32'd1);
      chk("wd_max_hold", 0, 32'(max_run), 32'd16);
      #2 reset = 1'b1;
      #1;
      chk("wd_clr", 0, 32'(watchdog), 32'd0);
      chk("wd_cnt_clr", 0, stall_cnt, 32'd0);
      chk("wd_max_clr", 0, 32'(max_run), 32'd0);
      reset = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
